// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes framed UART bytes (cmd, addr hi, addr lo, [len], data) into character-buffer writes.
// Define UART_CMD_TIMEOUT_EN to build the inter-byte timeout that aborts stalled frames.
module uart_cmd_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned BUF_DEPTH      = 2400,
  parameter logic [7:0]  CMD_WRITE      = 8'hA5,
  parameter logic [7:0]  CMD_BURST      = 8'hA6,
  parameter int unsigned TIMEOUT_CYCLES = 11285
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rx_wr_i,
  input  logic [7:0]            rx_data_i,
  output logic                  buf_we_o,
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  output logic [7:0]            buf_data_o,
  output logic                  cmd_done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    LEN     = 3'd3,
    DATA    = 3'd4
  } state_t;

  // The 16-bit frame address is truncated to ADDR_WIDTH, so ADDR_WIDTH must not exceed 16.
  localparam logic [16:0]           DEPTH_17   = 17'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LAST = ADDR_WIDTH'(BUF_DEPTH - 1);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit timeout counter");
  end

  state_t                state_reg, state_next;
  logic                  wr_d_reg;
  logic                  burst_reg, burst_next;
  logic [7:0]            addr_hi_reg, addr_hi_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [8:0]            remain_reg, remain_next;
  logic                  suppress_reg, suppress_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] buf_addr_reg, buf_addr_next;
  logic [7:0]            buf_data_reg, buf_data_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  logic        byte_stb;
  logic        tmo_hit;
  logic [15:0] addr16;

  // wr_d resets high so a level already present at reset release is not a byte.
  assign byte_stb = rx_wr_i & ~wr_d_reg;
  assign addr16   = {addr_hi_reg, rx_data_i};

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg;

  assign tmo_hit = (state_reg != IDLE) && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt_reg <= '0;
    end else if (byte_stb || state_next == IDLE) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    burst_next    = burst_reg;
    addr_hi_next  = addr_hi_reg;
    addr_next     = addr_reg;
    remain_next   = remain_reg;
    suppress_next = suppress_reg;
    we_next       = 1'b0;
    buf_addr_next = buf_addr_reg;
    buf_data_next = buf_data_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (byte_stb) begin
      unique case (state_reg)
        IDLE: begin
          if (rx_data_i == CMD_WRITE) begin
            burst_next = 1'b0;
            state_next = ADDR_HI;
          end else if (rx_data_i == CMD_BURST) begin
            burst_next = 1'b1;
            state_next = ADDR_HI;
          end else begin
            err_next = 1'b1;
          end
        end
        ADDR_HI: begin
          addr_hi_next = rx_data_i;
          state_next   = ADDR_LO;
        end
        ADDR_LO: begin
          // An out-of-range frame still consumes its bytes, with writes suppressed.
          addr_next     = addr16[ADDR_WIDTH-1:0];
          suppress_next = ({1'b0, addr16} >= DEPTH_17);
          err_next      = ({1'b0, addr16} >= DEPTH_17);
          state_next    = burst_reg ? LEN : DATA;
        end
        LEN: begin
          remain_next = (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
          state_next  = DATA;
        end
        DATA: begin
          if (!suppress_reg) begin
            we_next       = 1'b1;
            buf_addr_next = addr_reg;
            buf_data_next = rx_data_i;
          end
          if (!burst_reg || remain_reg == 9'd1) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            remain_next = remain_reg - 9'd1;
            addr_next   = (addr_reg == DEPTH_LAST) ? '0 : addr_reg + ADDR_WIDTH'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= IDLE;
      wr_d_reg     <= 1'b1;
      burst_reg    <= 1'b0;
      addr_hi_reg  <= '0;
      addr_reg     <= '0;
      remain_reg   <= '0;
      suppress_reg <= 1'b0;
      we_reg       <= 1'b0;
      buf_addr_reg <= '0;
      buf_data_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_d_reg     <= rx_wr_i;
      burst_reg    <= burst_next;
      addr_hi_reg  <= addr_hi_next;
      addr_reg     <= addr_next;
      remain_reg   <= remain_next;
      suppress_reg <= suppress_next;
      we_reg       <= we_next;
      buf_addr_reg <= buf_addr_next;
      buf_data_reg <= buf_data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign buf_we_o   = we_reg;
  assign buf_addr_o = buf_addr_reg;
  assign buf_data_o = buf_data_reg;
  assign cmd_done_o = done_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus random frames against a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int TMO   = 11285;
  localparam int DEPTH = 2400;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_wr = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [7:0]  buf_data;
  logic        cmd_done;
  logic        err;

  uart_cmd_ctrl dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .rx_wr_i   (rx_wr),
    .rx_data_i (rx_data),
    .buf_we_o  (buf_we),
    .buf_addr_o(buf_addr),
    .buf_data_o(buf_data),
    .cmd_done_o(cmd_done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stb_cyc = 0;
  int we_seen = 0, done_seen = 0, err_seen = 0;
  int exp_we = 0, exp_done = 0, exp_err = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  seq[$];
  logic [11:0] last_addr = 12'h000;
  logic [7:0]  last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      we_seen   += int'(buf_we);
      done_seen += int'(cmd_done);
      err_seen  += int'(err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: byte position in the frame decides its meaning; write address is base+k mod depth.
  task automatic model_byte(input logic [7:0] b, output logic ew, output logic ed, output logic ee);
    int n, hdr, base, total, k;
    logic burst;
    ew = 1'b0; ed = 1'b0; ee = 1'b0;
    frame_q.push_back(b);
    n = frame_q.size();
    if (n == 1) begin
      if (b != 8'hA5 && b != 8'hA6) begin
        ee = 1'b1;
        frame_q.delete();
        $display("byte 0x%02h rejected in idle", b);
      end
    end else if (n >= 3) begin
      burst = (frame_q[0] == 8'hA6);
      base  = int'(frame_q[1]) * 256 + int'(frame_q[2]);
      hdr   = burst ? 4 : 3;
      if (n == 3) begin
        ee = (base >= DEPTH);
      end else if (n > hdr) begin
        total = burst ? ((frame_q[3] == 8'h00) ? 256 : int'(frame_q[3])) : 1;
        k = n - hdr - 1;
        if (base < DEPTH) begin
          ew = 1'b1;
          last_addr = 12'((base + k) % DEPTH);
          last_data = b;
        end
        if (k == total - 1) begin
          ed = 1'b1;
          $display("frame %s base=0x%04h bytes=%0d writes=%0d", burst ? "burst" : "single",
                   base, total, (base < DEPTH) ? total : 0);
          frame_q.delete();
        end
      end
    end
    exp_we += int'(ew); exp_done += int'(ed); exp_err += int'(ee);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    logic ew, ed, ee;
    model_byte(b, ew, ed, ee);
    @(negedge clk);
    rx_data = b;
    rx_wr   = 1'b1;
    stb_cyc = cyc;
    @(negedge clk);
    check("we", buf_we, ew);
    check("done", cmd_done, ed);
    check("err", err, ee);
    check("addr", buf_addr, last_addr);
    check("data", buf_data, last_data);
    repeat (hold - 1) @(negedge clk);
    rx_wr   = 1'b0;
    rx_data = 8'($urandom_range(0, 255));
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i], $urandom_range(1, 4), $urandom_range(1, 3));
    seq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_we", buf_we, 1'b0);
    check("rst_addr", buf_addr, 12'h000);
    check("rst_data", buf_data, 8'h00);
    check("rst_done", cmd_done, 1'b0);
    check("rst_err", err, 1'b0);
    frame_q.delete();
    last_addr = 12'h000;
    last_data = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int base, len, sel, seen, delta, err_before;
    logic burst;
    logic [7:0] b;

    do_reset();

    // Single write
    seq = '{8'hA5, 8'h01, 8'h2C, 8'h41};
    send_seq();
    check("single_addr", buf_addr, 12'h12C);
    check("single_data", buf_data, 8'h41);

    // Burst crossing the end of the buffer
    seq = '{8'hA6, 8'h09, 8'h5E, 8'h03, 8'h10, 8'h11, 8'h12};
    send_seq();
    check("wrap_addr", buf_addr, 12'h000);
    check("wrap_data", buf_data, 8'h12);

    // Out-of-range address: frame consumed, no write
    seq = '{8'hA5, 8'h0A, 8'h00, 8'h55};
    send_seq();

    // Unknown command byte
    send_byte(8'h33, 2, 2);

    // Stalled frame
    seq = '{8'hA5, 8'h01};
    send_seq();
`ifdef UART_CMD_TIMEOUT_EN
    seen = 0; delta = 0;
    for (int i = 0; i < TMO + 20 && seen == 0; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        seen  = 1;
        delta = cyc - stb_cyc;
        check("tmo_no_done", cmd_done, 1'b0);
      end
    end
    check("tmo_seen", seen, 1);
    check("tmo_window", (delta >= TMO && delta <= TMO + 2) ? 1 : 0, 1);
    $display("timeout abort after %0d cycles", delta);
    frame_q.delete();
    exp_err++;
`else
    err_before = err_seen;
    repeat (TMO + 50) @(negedge clk);
    #1;
    check("no_tmo_err", err_seen, err_before);
    do_reset();
`endif
    seq = '{8'hA5, 8'h00, 8'h00, 8'h7E};
    send_seq();
    check("after_tmo_addr", buf_addr, 12'h000);
    check("after_tmo_data", buf_data, 8'h7E);

    // Reset in the middle of a burst
    seq = '{8'hA6, 8'h00, 8'h10, 8'h04, 8'hAA, 8'hBB};
    send_seq();
    do_reset();
    send_byte(8'hCC, 1, 2);

    // Level already high across reset release
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rx_data = 8'hA5;
    rx_wr   = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    frame_q.delete();
    last_addr = 12'h000;
    last_data = 8'h00;
    repeat (5) @(negedge clk);
    rx_wr = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h01, 1, 2);

    // Long level is one byte
    @(negedge clk); #1;
    err_before = err_seen;
    send_byte(8'h33, 40, 2);
    @(negedge clk); #1;
    check("long_level_one_err", err_seen - err_before, 1);

    // Maximum-length burst wrapping the buffer
    seq = '{8'hA6, 8'h08, 8'hFC, 8'h00};
    for (int i = 0; i < 256; i++) seq.push_back(8'($urandom_range(0, 255)));
    send_seq();
    check("burst256_addr", buf_addr, 12'd155);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5 || b == 8'hA6) b = 8'h00;
        seq.push_back(b);
      end else begin
        burst = (sel > 3);
        case ($urandom_range(0, 3))
          0:       base = $urandom_range(DEPTH, 65535);
          1:       base = $urandom_range(DEPTH - 8, DEPTH - 1);
          default: base = $urandom_range(0, DEPTH - 1);
        endcase
        len = burst ? $urandom_range(1, 8) : 1;
        seq.push_back(burst ? 8'hA6 : 8'hA5);
        seq.push_back(8'(base >> 8));
        seq.push_back(8'(base & 255));
        if (burst) seq.push_back(8'(len));
        for (int i = 0; i < len; i++) seq.push_back(8'($urandom_range(0, 255)));
      end
      send_seq();
    end

    repeat (3) @(negedge clk);
    #1;
    check("total_we", we_seen, exp_we);
    check("total_done", done_seen, exp_done);
    check("total_err", err_seen, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
